// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store control unit: FSM states,
// RV32I width codes and request legality/alignment checks.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FLT  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Stores only have signed width codes; loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == 2'd1) && lane[0]) || ((size == 2'd2) && (lane != 2'b00));
    endfunction

    // Clears the low address bits that the access width does not use.
    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd1:    return {lane[1], 1'b0};
            2'd2:    return 2'b00;
            default: return lane;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle between the execute stage and lsu_ctrl.
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// req_* are ignored while req_ready is low. load_valid and fault are
// single-cycle pulses with no back-pressure; load_data holds until the next load.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;

    modport master (
        output req_valid, req_we, req_funct3, req_adr, req_wdata,
        input  req_ready, load_data, load_valid, fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_adr, req_wdata,
        output req_ready, load_data, load_valid, fault
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane extract with sign/zero extension, and
// little-endian sub-word merge of store data into the word read from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (lane)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_ext = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_ext = {{16{half_v[15]}}, half_v};
            F3_BU:   load_ext = {24'd0, byte_v};
            F3_HU:   load_ext = {16'd0, half_v};
            default: load_ext = rdata;
        endcase

        merged = rdata;
        case (funct3[1:0])
            2'd0: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            2'd1: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a word-wide data memory. Optional macro
// LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of being force-aligned.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    lsu_if.slave        bus,
    output logic [31:0] mem_adr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output lsu_state_e  state_dbg
);

    lsu_state_e  state;
    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [1:0]  cap_lane;
    logic [31:0] cap_wdata;
    logic        acc_fault;
    logic [1:0]  acc_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign state_dbg = state;

    always_comb begin
        acc_fault = !f3_legal(bus.req_we, bus.req_funct3);
        acc_lane  = bus.req_adr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        acc_fault = acc_fault || misaligned(bus.req_funct3[1:0], bus.req_adr[1:0]);
`else
        acc_lane  = align_lane(bus.req_funct3[1:0], bus.req_adr[1:0]);
`endif
    end

    lsu_align u_align (
        .funct3   (cap_f3),
        .lane     (cap_lane),
        .rdata    (mem_rdata),
        .wdata    (cap_wdata),
        .load_ext (load_ext),
        .merged   (merged)
    );

    // mem_wdata doubles as the merge register for sub-word stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.load_data  <= 32'd0;
            bus.load_valid <= 1'b0;
            bus.fault      <= 1'b0;
            mem_adr        <= 32'd0;
            mem_we         <= 1'b0;
            mem_wdata      <= 32'd0;
            cap_we         <= 1'b0;
            cap_f3         <= 3'd0;
            cap_lane       <= 2'd0;
            cap_wdata      <= 32'd0;
        end else begin
            bus.load_valid <= 1'b0;
            bus.fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        cap_we        <= bus.req_we;
                        cap_f3        <= bus.req_funct3;
                        cap_lane      <= acc_lane;
                        cap_wdata     <= bus.req_wdata;
                        if (acc_fault) begin
                            state <= FLT;
                        end else begin
                            mem_adr <= {bus.req_adr[31:2], 2'b00};
                            if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                                state     <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= bus.req_wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (cap_we) begin
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state          <= IDLE;
                        bus.req_ready  <= 1'b1;
                        bus.load_data  <= load_ext;
                        bus.load_valid <= 1'b1;
                    end
                end
                WR: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    mem_we        <= 1'b0;
                end
                FLT: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.fault     <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    mem_we        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl against a small word memory model; expectations
// follow LSU_MISALIGN_TRAP_EN when the bench is built with it defined.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_adr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    lsu_state_e  state_dbg;

    lsu_if bus();

    lsu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .mem_adr   (mem_adr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- memory model (single owner of mem) ----------------
    logic [31:0] mem [0:63];
    logic        bd_en = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_val = 32'd0;
    int          we_cnt = 0;

    assign mem_rdata = mem[mem_adr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr[7:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end else if (bd_en) begin
            mem[bd_idx] <= bd_val;
        end
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld = 32'd0;

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [7:0] adr, input logic [31:0] val);
        @(negedge clk);
        bd_en  = 1'b1;
        bd_idx = adr[7:2];
        bd_val = val;
        @(posedge clk);
        #1 bd_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] adr,
                         input logic [31:0] wdata, output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready_timeout: req_ready=%b required 1", bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_adr    = adr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Watches four cycles after an accept; cycle n is the negedge after the nth edge.
    task automatic observe(output int lv_at, output int lv_cnt, output int flt_at,
                           output int flt_cnt, output int busy, output logic [31:0] ld);
        lv_at = 0; lv_cnt = 0; flt_at = 0; flt_cnt = 0; busy = 0; ld = 32'd0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (bus.load_valid === 1'b1) begin
                lv_cnt++;
                if (lv_at == 0) lv_at = n;
                ld = bus.load_data;
            end
            if (bus.fault === 1'b1) begin
                flt_cnt++;
                if (flt_at == 0) flt_at = n;
            end
            if (bus.req_ready !== 1'b1) busy++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_adr = 32'd0; bus.req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1)     begin failures++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.load_data !== 32'd0)    begin failures++; $display("FAIL reset_load_data: got %h want 0", bus.load_data); end
        checks++; if (bus.load_valid !== 1'b0)    begin failures++; $display("FAIL reset_load_valid: got %b want 0", bus.load_valid); end
        checks++; if (bus.fault !== 1'b0)         begin failures++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
        checks++; if (mem_we !== 1'b0)            begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_adr !== 32'd0)          begin failures++; $display("FAIL reset_mem_adr: got %h want 0", mem_adr); end
        checks++; if (mem_wdata !== 32'd0)        begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (state_dbg !== IDLE)         begin failures++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [8] = '{F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_BU, F3_W, F3_HU};
        logic [7:0]  adr [8] = '{8'h11, 8'h11, 8'h12, 8'h12, 8'h10, 8'h13, 8'h10, 8'h10};
        logic [31:0] exp [8] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                 32'hFFFFFFBB, 32'h00000088, 32'h8899AABB, 32'h0000AABB};
        int lv_at, lv_cnt, flt_at, flt_cnt, busy, waited, w0;
        logic [31:0] ld, want;
        preload(8'h10, 32'h8899AABB);
        w0 = we_cnt;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exp[i]);
            issue(1'b0, f3[i], {24'd0, adr[i]}, 32'h0, waited);
            observe(lv_at, lv_cnt, flt_at, flt_cnt, busy, ld);
            want = exp_q.pop_front();
            last_ld = want;
            checks++; if (lv_at != 2)  begin failures++; $display("FAIL load%0d_latency: got %0d want 2", i, lv_at); end
            checks++; if (lv_cnt != 1) begin failures++; $display("FAIL load%0d_pulse_count: got %0d want 1", i, lv_cnt); end
            checks++; if (ld !== want) begin failures++; $display("FAIL load%0d_data: got %h want %h", i, ld, want); end
            checks++; if (busy != 1)   begin failures++; $display("FAIL load%0d_busy: got %0d want 1", i, busy); end
        end
        checks++; if (we_cnt != w0) begin failures++; $display("FAIL load_no_write: got %0d writes want 0", we_cnt - w0); end
    endtask

    task automatic test_store_sub();
        logic [2:0]  f3  [4] = '{F3_H, F3_B, F3_B, F3_H};
        logic [7:0]  adr [4] = '{8'h22, 8'h21, 8'h23, 8'h20};
        logic [31:0] wd  [4] = '{32'h0000BEEF, 32'h12345677, 32'h000000A0, 32'hFFFF1234};
        logic [31:0] exp [4] = '{32'hBEEF3344, 32'hBEEF7744, 32'hA0EF7744, 32'hA0EF1234};
        int lv_at, lv_cnt, flt_at, flt_cnt, busy, waited, w0;
        logic [31:0] ld;
        preload(8'h20, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            w0 = we_cnt;
            issue(1'b1, f3[i], {24'd0, adr[i]}, wd[i], waited);
            observe(lv_at, lv_cnt, flt_at, flt_cnt, busy, ld);
            checks++; if (busy != 2)          begin failures++; $display("FAIL sub%0d_busy: got %0d want 2", i, busy); end
            checks++; if (we_cnt - w0 != 1)   begin failures++; $display("FAIL sub%0d_we_cycles: got %0d want 1", i, we_cnt - w0); end
            checks++; if (mem[8] !== exp[i])  begin failures++; $display("FAIL sub%0d_mem: got %h want %h", i, mem[8], exp[i]); end
            checks++; if (lv_cnt != 0)        begin failures++; $display("FAIL sub%0d_no_load_valid: got %0d want 0", i, lv_cnt); end
        end
        checks++; if (bus.load_data !== last_ld) begin failures++; $display("FAIL store_keeps_load_data: got %h want %h", bus.load_data, last_ld); end
    endtask

    task automatic test_back_to_back();
        int lv_at, lv_cnt, flt_at, flt_cnt, busy, waited;
        logic [31:0] ld;
        preload(8'h30, 32'h0);
        issue(1'b1, F3_W, 32'h30, 32'hDEADBEEF, waited);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1)           begin failures++; $display("FAIL sw_mem_we: got %b want 1", mem_we); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem_wdata: got %h want deadbeef", mem_wdata); end
        checks++; if (bus.req_ready !== 1'b0)    begin failures++; $display("FAIL sw_ready_low: got %b want 0", bus.req_ready); end
        issue(1'b0, F3_W, 32'h30, 32'h0, waited);
        checks++; if (waited != 0) begin failures++; $display("FAIL b2b_accept_wait: got %0d want 0", waited); end
        observe(lv_at, lv_cnt, flt_at, flt_cnt, busy, ld);
        last_ld = 32'hDEADBEEF;
        checks++; if (ld !== 32'hDEADBEEF)    begin failures++; $display("FAIL b2b_load_data: got %h want deadbeef", ld); end
        checks++; if (lv_at != 2)             begin failures++; $display("FAIL b2b_latency: got %0d want 2", lv_at); end
        checks++; if (mem[12] !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_mem: got %h want deadbeef", mem[12]); end
    endtask

    task automatic test_misalign();
        logic        we  [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3  [3] = '{F3_W, F3_H, F3_W};
        logic [7:0]  adr [3] = '{8'h41, 8'h43, 8'h42};
        logic [31:0] exp [3] = '{32'hCAFEF00D, 32'hFFFFCAFE, 32'h11111111};
        int lv_at, lv_cnt, flt_at, flt_cnt, busy, waited, w0;
        logic [31:0] ld;
        preload(8'h40, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            w0 = we_cnt;
            issue(we[i], f3[i], {24'd0, adr[i]}, 32'h11111111, waited);
            observe(lv_at, lv_cnt, flt_at, flt_cnt, busy, ld);
`ifdef LSU_MISALIGN_TRAP_EN
            checks++; if (flt_at != 2 || flt_cnt != 1) begin failures++; $display("FAIL mis%0d_fault: at %0d count %0d want at 2 count 1", i, flt_at, flt_cnt); end
            checks++; if (lv_cnt != 0)                 begin failures++; $display("FAIL mis%0d_no_load_valid: got %0d want 0", i, lv_cnt); end
            checks++; if (we_cnt != w0)                begin failures++; $display("FAIL mis%0d_no_write: got %0d want 0", i, we_cnt - w0); end
            checks++; if (mem[16] !== 32'hCAFEF00D)    begin failures++; $display("FAIL mis%0d_mem: got %h want cafef00d", i, mem[16]); end
`else
            checks++; if (flt_cnt != 0) begin failures++; $display("FAIL mis%0d_no_fault: got %0d want 0", i, flt_cnt); end
            if (we[i]) begin
                checks++; if (we_cnt - w0 != 1)    begin failures++; $display("FAIL mis%0d_write: got %0d want 1", i, we_cnt - w0); end
                checks++; if (mem[16] !== exp[i])  begin failures++; $display("FAIL mis%0d_mem: got %h want %h", i, mem[16], exp[i]); end
            end else begin
                last_ld = exp[i];
                checks++; if (lv_at != 2)   begin failures++; $display("FAIL mis%0d_latency: got %0d want 2", i, lv_at); end
                checks++; if (ld !== exp[i]) begin failures++; $display("FAIL mis%0d_data: got %h want %h", i, ld, exp[i]); end
            end
`endif
        end
        checks++; if (bus.load_data !== last_ld) begin failures++; $display("FAIL mis_load_data_hold: got %h want %h", bus.load_data, last_ld); end
    endtask

    task automatic test_illegal();
        logic       we [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] f3 [5] = '{3'd3, 3'd6, 3'd7, 3'd3, 3'd4};
        int lv_at, lv_cnt, flt_at, flt_cnt, busy, waited, w0;
        logic [31:0] ld;
        for (int i = 0; i < 5; i++) begin
            w0 = we_cnt;
            issue(we[i], f3[i], 32'h10, 32'h55555555, waited);
            observe(lv_at, lv_cnt, flt_at, flt_cnt, busy, ld);
            checks++; if (flt_at != 2)  begin failures++; $display("FAIL ill%0d_fault_at: got %0d want 2", i, flt_at); end
            checks++; if (flt_cnt != 1) begin failures++; $display("FAIL ill%0d_fault_count: got %0d want 1", i, flt_cnt); end
            checks++; if (lv_cnt != 0)  begin failures++; $display("FAIL ill%0d_no_load_valid: got %0d want 0", i, lv_cnt); end
            checks++; if (we_cnt != w0) begin failures++; $display("FAIL ill%0d_no_write: got %0d want 0", i, we_cnt - w0); end
            checks++; if (busy != 1)    begin failures++; $display("FAIL ill%0d_busy: got %0d want 1", i, busy); end
        end
        checks++; if (mem[4] !== 32'h8899AABB)   begin failures++; $display("FAIL ill_mem: got %h want 8899aabb", mem[4]); end
        checks++; if (bus.load_data !== last_ld) begin failures++; $display("FAIL ill_load_data_hold: got %h want %h", bus.load_data, last_ld); end
    endtask

    task automatic test_reset_mid();
        int lv_at, lv_cnt, flt_at, flt_cnt, busy, waited, w0;
        logic [31:0] ld;
        preload(8'h50, 32'hA5A5A5A5);
        w0 = we_cnt;
        issue(1'b1, F3_B, 32'h51, 32'h0000003C, waited);
        @(posedge clk);
        #2;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rmid_in_wr: mem_we=%b want 1", mem_we); end
        #1 rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0)         begin failures++; $display("FAIL rmid_mem_we_drop: got %b want 0", mem_we); end
        checks++; if (bus.req_ready !== 1'b1)  begin failures++; $display("FAIL rmid_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.load_data !== 32'd0) begin failures++; $display("FAIL rmid_load_data: got %h want 0", bus.load_data); end
        checks++; if (mem_adr !== 32'd0)       begin failures++; $display("FAIL rmid_mem_adr: got %h want 0", mem_adr); end
        checks++; if (mem_wdata !== 32'd0)     begin failures++; $display("FAIL rmid_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (state_dbg !== IDLE)      begin failures++; $display("FAIL rmid_state: got %0d want IDLE", state_dbg); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem[20] !== 32'hA5A5A5A5) begin failures++; $display("FAIL rmid_target_word: got %h want a5a5a5a5", mem[20]); end
        checks++; if (we_cnt != w0)             begin failures++; $display("FAIL rmid_no_write: got %0d want 0", we_cnt - w0); end
        // Reset while a load is in RD must swallow its load_valid.
        issue(1'b0, F3_W, 32'h10, 32'h0, waited);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        observe(lv_at, lv_cnt, flt_at, flt_cnt, busy, ld);
        checks++; if (lv_cnt != 0)             begin failures++; $display("FAIL rmid_load_discard: got %0d want 0", lv_cnt); end
        checks++; if (bus.load_data !== 32'd0) begin failures++; $display("FAIL rmid_load_data_after: got %h want 0", bus.load_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_ext();
        test_store_sub();
        test_back_to_back();
        test_misalign();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
